car_collision: RTL and testbench
================================

# car_collision

Collision checker for the frog-crossing game. Once per frame it snapshots the frog position and every car position published by the car controllers. It then compares the frog's bounding box against one car per clock and raises a sticky hit flag, with the offending car's index, until the game FSM acknowledges it. It sits between the per-lane car controllers and the game-state FSM.

## Interface
- `N_CARS`, default 4: number of cars checked; 1..16.
- `CAR_W`, default 32: car width in pixels.
- `CAR_H`, default 16: car height in pixels.
- `FROG_W`, default 16: frog width in pixels.
- `FROG_H`, default 16: frog height in pixels.
- `GAME_WIDTH`, default 640: playfield width; car X wraps modulo this value.

- `i_Clk`  in  1  system clock; one clock domain.
- `i_Reset_n`  in  1  reset; asynchronous assertion, active-low.
- `i_game_state`  in  2  game state; 2'b01 = running.
- `i_frame_tick`  in  1  one-cycle pulse; starts a scan.
- `i_frogX`  in  10  frog left edge.
- `i_frogY`  in  9  frog top edge.
- `i_carX`  in  10*N_CARS  car k left edge at bits [10k+9:10k].
- `i_carY`  in  9*N_CARS  car k top edge at bits [9k+8:9k].
- `i_hit_ack`  in  1  game FSM acknowledge; clears the hit.
- `o_hit`  out  1  collision flag; sticky.
- `o_hit_idx`  out  4  index of the colliding car.
- `o_busy`  out  1  high while a scan is in progress.

## Operation
- **States:** IDLE, SCAN, HIT.
- **IDLE:**
  - On `i_frame_tick`=1 with `i_game_state`=2'b01, register all frog and car inputs into a snapshot, set idx=0, and go to SCAN.
  - Otherwise stay in IDLE.
- **SCAN:** each cycle, test snapshot car idx against the snapshot frog.
  - Overlap X: `carX < frogX+FROG_W` and `frogX < carX+CAR_W`. Evaluate at 11 bits with no truncation.
  - Overlap Y: `carY < frogY+FROG_H` and `frogY < carY+CAR_H`. Evaluate at 10 bits.
  - Edges are half-open: boxes that merely touch do not collide.
  - Hit when X and Y both overlap. On hit: latch `o_hit_idx`=idx, set `o_hit`=1, go to HIT. The scan stops there, so the lowest-index colliding car is reported.
  - No hit and idx=N_CARS-1: go to IDLE. Otherwise idx+1.
  - If `i_game_state`≠2'b01 in any SCAN cycle: abort to IDLE and do not evaluate that cycle's car.
- **HIT:**
  - `o_hit` holds and `o_hit_idx` is stable.
  - `i_hit_ack`=1 clears `o_hit` and returns to IDLE.
  - `i_game_state` changes do not clear the hit.
- **Ignored inputs:**
  - `i_frame_tick` is ignored in SCAN and HIT.
  - A tick coinciding with an ack in HIT is dropped.
  - `i_hit_ack` outside HIT has no effect.
- **Reset:**
  - State IDLE; `o_hit`=0, `o_hit_idx`=0, `o_busy`=0, idx=0; snapshot cleared.
  - Reset asserted mid-scan or in HIT returns to IDLE immediately.

## Timing
- All outputs are registered.
- Tick sampled at edge E0; car k is evaluated at edge E(k+1).
- A hit on car k makes `o_hit` and `o_hit_idx` valid after E(k+1).
- `o_busy` is high after E0. It goes low after the edge that ends the scan: the hit edge, E(N_CARS) on a clean scan, or the abort edge.
- Worst-case scan length: N_CARS cycles. Frame ticks must be at least N_CARS+1 cycles apart.
- `i_hit_ack` sampled high at edge Ea gives `o_hit`=0 after Ea.
- Inputs changing after E0 do not affect the scan in progress.

## Configuration
- Macro: `CAR_COLLISION_WRAP_EN`.
- **Defined:**
  - A car with `carX+CAR_W > GAME_WIDTH` also occupies the wrapped segment [0, carX+CAR_W-GAME_WIDTH).
  - X overlap is true if either the unwrapped test or `frogX < carX+CAR_W-GAME_WIDTH` holds.
- **Not defined:**
  - Only the unwrapped 11-bit test is used.
  - The wrapped portion of a car never collides.

## Test plan
- **Reset:** assert `i_Reset_n`=0 mid-scan → `o_hit`=0, `o_hit_idx`=0, `o_busy`=0 immediately; the next tick starts a fresh scan.
- **Basic hit:** defaults, frog (100,200), car2 at (90,200), other cars at Y=0, tick at E0 → `o_busy` high after E0, `o_hit`=1 with `o_hit_idx`=2 after E3; held for 20 cycles; ack → `o_hit`=0 next edge.
- **Edge cases:**
  - Frog X=100, car0 X=68 (spans 68..99), same Y → no hit; `o_busy` low after E4.
  - Car0 X=69 → hit, idx 0.
  - Frog Y=200, car0 Y=184 → no hit; Y=185 → hit.
- **Wrap:** GAME_WIDTH=640, car1 X=630, frog X=10, same Y.
  - With `CAR_COLLISION_WRAP_EN`: `o_hit`=1, idx 1 after E2.
  - Without the macro: no hit.
- **Priority and abort:**
  - Cars 1 and 3 both overlap → `o_hit_idx`=1.
  - Rerun with only car3 overlapping and `i_game_state`=2'b00 at E2 → `o_busy`=0 after E2, `o_hit` stays 0.
- **Ignored events:**
  - In HIT, pulse `i_frame_tick` alone → no change.
  - Pulse `i_hit_ack` and `i_frame_tick` together → IDLE, `o_hit`=0, no new scan.

Source files
------------

// File: rtl/car_collision.sv
// Frame-based frog/car collision checker: snapshots positions on a frame tick,
// scans one car per clock and latches a sticky hit with the lowest colliding index.
// Optional macro CAR_COLLISION_WRAP_EN: cars crossing the right edge also
// occupy the wrapped segment at the left of the playfield.
// Ports: i_Clk, i_Reset_n (async, active-low), i_game_state, i_frame_tick,
//   i_frogX/i_frogY, i_carX/i_carY (packed per car), i_hit_ack;
//   o_hit (sticky), o_hit_idx, o_busy.
module car_collision #(
  parameter int N_CARS     = 4,
  parameter int CAR_W      = 32,
  parameter int CAR_H      = 16,
  parameter int FROG_W     = 16,
  parameter int FROG_H     = 16,
  parameter int GAME_WIDTH = 640
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic [1:0]            i_game_state,
  input  logic                  i_frame_tick,
  input  logic [9:0]            i_frogX,
  input  logic [8:0]            i_frogY,
  input  logic [10*N_CARS-1:0]  i_carX,
  input  logic [9*N_CARS-1:0]   i_carY,
  input  logic                  i_hit_ack,
  output logic                  o_hit,
  output logic [3:0]            o_hit_idx,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [3:0] LAST   = 4'(N_CARS - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic                 hit_q, hit_d;
  logic [3:0]           hit_idx_q, hit_idx_d;
  logic                 busy_q, busy_d;
  logic [9:0]           frog_x_q, frog_x_d;
  logic [8:0]           frog_y_q, frog_y_d;
  logic [10*N_CARS-1:0] car_x_q, car_x_d;
  logic [9*N_CARS-1:0]  car_y_q, car_y_d;

  logic [9:0]  car_x;
  logic [8:0]  car_y;
  logic [10:0] cx, fx, car_r, frog_r;
  logic [9:0]  cy, fy, car_b, frog_b;
  logic        x_ovl, y_ovl, hit_now;

  // Bounding boxes compared one bit wider than the positions so the
  // right/bottom edges never truncate.
  always_comb begin
    car_x  = car_x_q[10*int'(idx_q) +: 10];
    car_y  = car_y_q[9*int'(idx_q) +: 9];
    cx     = {1'b0, car_x};
    fx     = {1'b0, frog_x_q};
    car_r  = cx + 11'(CAR_W);
    frog_r = fx + 11'(FROG_W);
    cy     = {1'b0, car_y};
    fy     = {1'b0, frog_y_q};
    car_b  = cy + 10'(CAR_H);
    frog_b = fy + 10'(FROG_H);
    x_ovl  = (cx < frog_r) && (fx < car_r);
`ifdef CAR_COLLISION_WRAP_EN
    if ((car_r > 11'(GAME_WIDTH)) && (fx < (car_r - 11'(GAME_WIDTH))))
      x_ovl = 1'b1;
`endif
    y_ovl   = (cy < frog_b) && (fy < car_b);
    hit_now = x_ovl && y_ovl;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    busy_d    = busy_q;
    frog_x_d  = frog_x_q;
    frog_y_d  = frog_y_q;
    car_x_d   = car_x_q;
    car_y_d   = car_y_q;
    case (state_q)
      S_IDLE: begin
        if (i_frame_tick && (i_game_state == RUN)) begin
          frog_x_d = i_frogX;
          frog_y_d = i_frogY;
          car_x_d  = i_carX;
          car_y_d  = i_carY;
          idx_d    = 4'd0;
          busy_d   = 1'b1;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (i_game_state != RUN) begin
          // Abort without evaluating this cycle's car.
          idx_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (hit_now) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
          busy_d    = 1'b0;
          state_d   = S_HIT;
        end else if (idx_q == LAST) begin
          idx_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_HIT: begin
        // A tick arriving with the ack is dropped.
        if (i_hit_ack) begin
          hit_d   = 1'b0;
          idx_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        hit_d   = 1'b0;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      busy_q    <= 1'b0;
      frog_x_q  <= '0;
      frog_y_q  <= '0;
      car_x_q   <= '0;
      car_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      busy_q    <= busy_d;
      frog_x_q  <= frog_x_d;
      frog_y_q  <= frog_y_d;
      car_x_q   <= car_x_d;
      car_y_q   <= car_y_d;
    end
  end

  assign o_hit     = hit_q;
  assign o_hit_idx = hit_idx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_car_collision.sv
// Self-checking bench for car_collision: outcome-level model plus
// hand-computed directed checks.
module tb_car_collision;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int CH = 16;
  localparam int FW = 16;
  localparam int FH = 16;
  localparam int GW = 640;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n = 1'b0;
  logic [1:0]    i_game_state = 2'b01;
  logic          i_frame_tick = 1'b0;
  logic [9:0]    i_frogX = 10'd100;
  logic [8:0]    i_frogY = 9'd200;
  logic [10*N-1:0] i_carX = '0;
  logic [9*N-1:0]  i_carY = '0;
  logic          i_hit_ack = 1'b0;
  logic          o_hit;
  logic [3:0]    o_hit_idx;
  logic          o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  car_collision dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
    .i_game_state(i_game_state), .i_frame_tick(i_frame_tick),
    .i_frogX(i_frogX), .i_frogY(i_frogY),
    .i_carX(i_carX), .i_carY(i_carY),
    .i_hit_ack(i_hit_ack),
    .o_hit(o_hit), .o_hit_idx(o_hit_idx), .o_busy(o_busy)
  );

  always #5 i_Clk = ~i_Clk;

  // Model: decide the whole scan outcome at the tick, then count cycles.
  logic m_hit = 1'b0;
  logic [3:0] m_idx = '0;
  logic m_busy = 1'b0;
  int m_left = 0;
  int m_k = -1;

  function automatic bit collide(int k);
    int cx, cy, fx, fy;
    bit xo, yo;
    cx = int'(i_carX[10*k +: 10]);
    cy = int'(i_carY[9*k +: 9]);
    fx = int'(i_frogX);
    fy = int'(i_frogY);
    xo = (cx < fx + FW) && (fx < cx + CW);
`ifdef CAR_COLLISION_WRAP_EN
    if (cx + CW > GW && fx < cx + CW - GW) xo = 1'b1;
`endif
    yo = (cy < fy + FH) && (fy < cy + CH);
    return xo && yo;
  endfunction

  function automatic int first_hit();
    for (int k = 0; k < N; k++)
      if (collide(k)) return k;
    return -1;
  endfunction

  always @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      m_hit  <= 1'b0;
      m_idx  <= '0;
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (m_hit) begin
      if (i_hit_ack) m_hit <= 1'b0;
    end else if (m_busy) begin
      if (i_game_state != 2'b01) begin
        m_busy <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          if (m_k >= 0) begin
            m_hit <= 1'b1;
            m_idx <= 4'(m_k);
          end
        end
      end
    end else if (i_frame_tick && i_game_state == 2'b01) begin
      int k;
      k = first_hit();
      m_k    <= k;
      m_left <= (k >= 0) ? k + 1 : N;
      m_busy <= 1'b1;
    end
  end

  always @(negedge i_Clk) begin
    if (chk_en) begin
      n_cmp++;
      if (o_hit !== m_hit || o_busy !== m_busy || o_hit_idx !== m_idx) begin
        n_bad++;
        $display("FAIL model t=%0t hit/busy/idx got %0b/%0b/%0d want %0b/%0b/%0d",
                 $time, o_hit, o_busy, o_hit_idx, m_hit, m_busy, m_idx);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic tick();
    i_frame_tick = 1'b1;
    @(negedge i_Clk);
    i_frame_tick = 1'b0;
  endtask

  task automatic ack();
    i_hit_ack = 1'b1;
    @(negedge i_Clk);
    i_hit_ack = 1'b0;
  endtask

  task automatic clear_cars();
    for (int k = 0; k < N; k++) begin
      i_carX[10*k +: 10] = 10'd300;
      i_carY[9*k +: 9]   = 9'd0;
    end
  endtask

  task automatic set_car(int k, int x, int y);
    i_carX[10*k +: 10] = 10'(x);
    i_carY[9*k +: 9]   = 9'(y);
  endtask

  initial begin
    clear_cars();
    cyc(3);
    i_Reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_hit", int'(o_hit), 0);
    chk("rst_idx", int'(o_hit_idx), 0);
    chk("rst_busy", int'(o_busy), 0);
    ack();
    cyc(1);

    // basic hit on car2
    set_car(2, 90, 200);
    tick();
    chk("basic_busy_e0", int'(o_busy), 1);
    cyc(2);
    chk("basic_nohit_e2", int'(o_hit), 0);
    cyc(1);
    chk("basic_hit_e3", int'(o_hit), 1);
    chk("basic_idx_e3", int'(o_hit_idx), 2);
    chk("basic_busy_e3", int'(o_busy), 0);
    i_game_state = 2'b00;
    cyc(20);
    i_game_state = 2'b01;
    chk("basic_held", int'(o_hit), 1);
    ack();
    chk("basic_ack", int'(o_hit), 0);

    // X edge: car0 at 68 touches frog at 100
    clear_cars();
    set_car(0, 68, 200);
    tick();
    cyc(3);
    chk("x68_busy_e3", int'(o_busy), 1);
    cyc(1);
    chk("x68_busy_e4", int'(o_busy), 0);
    chk("x68_hit", int'(o_hit), 0);
    set_car(0, 69, 200);
    tick();
    cyc(1);
    chk("x69_hit", int'(o_hit), 1);
    chk("x69_idx", int'(o_hit_idx), 0);
    ack();

    // Y edge
    set_car(0, 100, 184);
    tick();
    cyc(4);
    chk("y184_hit", int'(o_hit), 0);
    set_car(0, 100, 185);
    tick();
    cyc(1);
    chk("y185_hit", int'(o_hit), 1);
    ack();

    // wrap: car1 at 630 spills into [0,22)
    clear_cars();
    i_frogX = 10'd10;
    set_car(1, 630, 200);
    tick();
    cyc(2);
`ifdef CAR_COLLISION_WRAP_EN
    chk("wrap_hit", int'(o_hit), 1);
    chk("wrap_idx", int'(o_hit_idx), 1);
`else
    chk("wrap_hit", int'(o_hit), 0);
`endif
    cyc(2);
    ack();
    i_frogX = 10'd100;

    // priority, with inputs moved after E0
    clear_cars();
    set_car(1, 100, 200);
    set_car(3, 100, 200);
    tick();
    clear_cars();
    cyc(2);
    chk("prio_idx", int'(o_hit_idx), 1);
    chk("prio_hit", int'(o_hit), 1);
    ack();

    // abort at E2
    set_car(3, 100, 200);
    tick();
    cyc(1);
    i_game_state = 2'b00;
    cyc(1);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_hit", int'(o_hit), 0);
    i_game_state = 2'b01;
    cyc(4);
    chk("abort_after", int'(o_hit), 0);

    // ignored tick in HIT, tick dropped with ack
    tick();
    cyc(4);
    chk("ign_hit", int'(o_hit), 1);
    chk("ign_idx", int'(o_hit_idx), 3);
    tick();
    chk("ign_tick_hit", int'(o_hit), 1);
    chk("ign_tick_busy", int'(o_busy), 0);
    i_hit_ack = 1'b1;
    i_frame_tick = 1'b1;
    @(negedge i_Clk);
    i_hit_ack = 1'b0;
    i_frame_tick = 1'b0;
    chk("ackt_hit", int'(o_hit), 0);
    chk("ackt_busy", int'(o_busy), 0);
    cyc(1);
    chk("ackt_busy2", int'(o_busy), 0);

    // reset mid-scan (hit_idx still 3 from before)
    clear_cars();
    set_car(2, 100, 200);
    tick();
    cyc(1);
    chk("mid_busy", int'(o_busy), 1);
    #1 i_Reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_hit", int'(o_hit), 0);
    chk("mid_rst_idx", int'(o_hit_idx), 0);
    @(negedge i_Clk);
    i_Reset_n = 1'b1;
    tick();
    cyc(3);
    chk("fresh_hit", int'(o_hit), 1);
    chk("fresh_idx", int'(o_hit_idx), 2);
    ack();
    cyc(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
